// File: rtl/codec_acc_pkg.sv
// Shared types and constants for the codec-to-accelerator feed scheduler.
// Holds the scheduler state encoding and the saturating drop-count helper.
package codec_acc_pkg;

    localparam int DATA_W_DEF = 20;
    localparam int DROP_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_ACK,
        ST_GAP
    } state_t;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/codec_rr_arb2.sv
// Two-way round-robin arbiter for the codec feed scheduler.
// A lone requester wins; with both requesting, the one not granted last wins.
module codec_rr_arb2
    import codec_acc_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    // Pick the winner from the request pattern and the previous grant
    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) begin
            grant_o = last_grant_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/codec_acc_feed_sched.sv
// Shares the accelerator data port between two codec sample sources.
// Grants round-robin, holds the word until ack or timeout, then idles a gap.
module codec_acc_feed_sched
    import codec_acc_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int TIMEOUT    = 64,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        req_valid,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    output logic [1:0]        req_ready,
    output logic [DATA_W-1:0] acc_data,
    output logic              acc_src,
    output logic              acc_valid,
    input  logic              acc_ack,
    output logic              timeout_err,
    input  logic              clear_err,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam state_t AFTER_S = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              src_q, src_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [WW-1:0]     wcnt_q, wcnt_d;
    logic [GW-1:0]     gcnt_q, gcnt_d;
    logic              err_q, err_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [1:0]        grant;
    logic [1:0]        ready_c;
    logic              drop_ev;

    codec_rr_arb2 u_arb (
        .valid_i      (req_valid),
        .last_grant_i (last_q),
        .grant_o      (grant)
    );

    // Next-state, grant and error bookkeeping
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        valid_d = valid_q;
        last_d  = last_q;
        wcnt_d  = wcnt_q;
        gcnt_d  = gcnt_q;
        err_d   = err_q;
        drop_d  = drop_q;
        ready_c = 2'b00;
        drop_ev = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable && (|req_valid)) begin
                    ready_c = grant;
                    data_d  = grant[1] ? req_data1 : req_data0;
                    src_d   = grant[1];
                    last_d  = grant[1];
                    valid_d = 1'b1;
                    wcnt_d  = '0;
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (acc_ack) begin
                    valid_d = 1'b0;
                    gcnt_d  = '0;
                    state_d = AFTER_S;
                end else if (wcnt_q == WW'(TIMEOUT - 1)) begin
                    valid_d = 1'b0;
                    drop_ev = 1'b1;
                    gcnt_d  = '0;
                    state_d = AFTER_S;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gcnt_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (drop_ev) begin
            err_d  = 1'b1;
            drop_d = clear_err ? DROP_W'(1) : sat_inc(drop_q);
        end else if (clear_err) begin
            err_d  = 1'b0;
            drop_d = '0;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            src_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b1;
            wcnt_q  <= '0;
            gcnt_q  <= '0;
            err_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            wcnt_q  <= wcnt_d;
            gcnt_q  <= gcnt_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    assign req_ready   = reset ? 2'b00 : ready_c;
    assign acc_data    = data_q;
    assign acc_src     = src_q;
    assign acc_valid   = valid_q;
    assign timeout_err = err_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_codec_acc_feed_sched.sv
// Bench for codec_acc_feed_sched: directed scenarios plus random traffic,
// all checked every cycle against a word-level reference model.
module tb_codec_acc_feed_sched;

    localparam int DW  = 20;
    localparam int TO  = 64;
    localparam int GAP = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [1:0]    req_valid = 2'b00;
    logic [DW-1:0] req_data0 = '0;
    logic [DW-1:0] req_data1 = '0;
    logic          acc_ack = 1'b0;
    logic          clear_err = 1'b0;
    logic [1:0]    req_ready;
    logic [DW-1:0] acc_data;
    logic          acc_src;
    logic          acc_valid;
    logic          timeout_err;
    logic [7:0]    drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    codec_acc_feed_sched #(.DATA_W(DW), .TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_data0   (req_data0),
        .req_data1   (req_data1),
        .req_ready   (req_ready),
        .acc_data    (acc_data),
        .acc_src     (acc_src),
        .acc_valid   (acc_valid),
        .acc_ack     (acc_ack),
        .timeout_err (timeout_err),
        .clear_err   (clear_err),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a word is either held (with how many cycles it has
    // been shown) or the port is resting for some remaining gap cycles.
    bit          m_live = 0;
    bit          m_busy;
    logic [DW-1:0] m_word;
    bit          m_src;
    int          m_held;
    int          m_gap;
    bit          m_last = 1;
    bit          m_err;
    int          m_drops;
    bit          m_drop;
    logic [1:0]  m_g;

    function automatic logic [1:0] pick(input logic [1:0] v, input bit last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_live = 1; m_busy = 0; m_word = '0; m_src = 0; m_held = 0;
            m_gap = 0; m_last = 1; m_err = 0; m_drops = 0;
        end else if (m_live) begin
            m_drop = 0;
            if (m_busy) begin
                if (acc_ack) begin
                    m_busy = 0; m_gap = GAP;
                end else if (m_held == TO) begin
                    m_busy = 0; m_gap = GAP; m_drop = 1;
                end else begin
                    m_held++;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (enable && req_valid != 2'b00) begin
                m_g = pick(req_valid, m_last);
                m_busy = 1; m_held = 1;
                m_src = m_g[1]; m_last = m_g[1];
                m_word = m_g[1] ? req_data1 : req_data0;
            end
            if (m_drop) begin
                m_err = 1;
                m_drops = clear_err ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
            end else if (clear_err) begin
                m_err = 0; m_drops = 0;
            end
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (m_live) begin
            logic [1:0] er;
            er = (!reset && enable && !m_busy && m_gap == 0) ?
                 pick(req_valid, m_last) : 2'b00;
            check("req_ready", req_ready, er);
            check("acc_valid", acc_valid, m_busy);
            if (m_busy) begin
                check("acc_data", acc_data, m_word);
                check("acc_src", acc_src, m_src);
            end
            check("timeout_err", timeout_err, m_err);
            check("drop_cnt", drop_cnt, m_drops);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rise(input string nm);
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (acc_valid) begin ok = 1; break; end
            cyc(1);
        end
        check(nm, ok, 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int vcyc[$];
    bit vsrc[$];
    int hi;
    int falls;
    bit prev;
    int pct;

    initial begin
        cyc(2);
        reset = 0;
        @(negedge clk);
        check("rst_valid", acc_valid, 0);
        check("rst_data", acc_data, 0);
        check("rst_drop", drop_cnt, 0);
        @(posedge clk); #1;

        // single source, ack in 4th valid cycle
        enable = 1; req_valid = 2'b01; req_data0 = 20'h12345;
        @(negedge clk);
        check("p1_ready", req_ready, 2'b01);
        cyc(1);
        req_valid = 2'b00;
        @(negedge clk);
        check("p1_data", acc_data, 20'h12345);
        check("p1_src", acc_src, 0);
        check("p1_valid", acc_valid, 1);
        cyc(3);
        check("p1_valid4", acc_valid, 1);
        acc_ack = 1;
        cyc(1);
        acc_ack = 0; req_valid = 2'b01;
        @(negedge clk);
        check("p1_gap_valid", acc_valid, 0);
        check("p1_gap1_ready", req_ready, 2'b00);
        cyc(1);
        @(negedge clk);
        check("p1_gap2_ready", req_ready, 2'b00);
        cyc(1);
        req_valid = 2'b00;

        // both valid, immediate ack: alternation and 4-cycle period
        req_valid = 2'b11; req_data0 = 20'h00A00; req_data1 = 20'h00B00;
        acc_ack = 1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (acc_valid) begin
                vcyc.push_back(i);
                vsrc.push_back(acc_src);
            end
        end
        #1;
        check("p2_words", vcyc.size() >= 5, 1);
        for (int k = 0; k < 5 && k < vcyc.size(); k++) begin
            check("p2_src", vsrc[k], (k % 2 == 0) ? 1 : 0);
            if (k > 0) check("p2_period", vcyc[k] - vcyc[k-1], 4);
        end
        req_valid = 2'b00;
        cyc(6);

        // no ack: timeout after 64 valid cycles, then saturate the counter
        acc_ack = 0; req_valid = 2'b01; req_data0 = 20'h0BEEF;
        wait_rise("p3_rise");
        hi = 0;
        for (int i = 0; i < 200 && acc_valid; i++) begin
            hi++;
            cyc(1);
        end
        check("p3_hold", hi, 64);
        @(negedge clk);
        check("p3_err", timeout_err, 1);
        check("p3_cnt", drop_cnt, 1);
        falls = 1; prev = 0;
        for (int i = 0; i < 25000 && falls < 300; i++) begin
            @(negedge clk);
            if (prev && !acc_valid) falls++;
            prev = acc_valid;
        end
        check("p3_falls", falls, 300);
        check("p3_sat", drop_cnt, 255);
        @(posedge clk); #1;
        req_valid = 2'b00;
        cyc(70);
        clear_err = 1;
        cyc(1);
        clear_err = 0;
        @(negedge clk);
        check("p3_clr_err", timeout_err, 0);
        check("p3_clr_cnt", drop_cnt, 0);
        @(posedge clk); #1;

        // ack on the last permitted cycle
        req_valid = 2'b01;
        wait_rise("p4_rise");
        req_valid = 2'b00;
        cyc(63);
        check("p4_still", acc_valid, 1);
        acc_ack = 1;
        cyc(1);
        acc_ack = 0;
        @(negedge clk);
        check("p4_valid", acc_valid, 0);
        check("p4_err", timeout_err, 0);
        check("p4_cnt", drop_cnt, 0);
        @(posedge clk); #1;
        cyc(4);

        // enable low blocks grants; in-flight word still completes
        enable = 0; req_valid = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("p5_ready", req_ready, 2'b00);
            check("p5_valid", acc_valid, 0);
        end
        @(posedge clk); #1;
        enable = 1;
        cyc(1);
        enable = 0;
        @(negedge clk);
        check("p5_inflight", acc_valid, 1);
        check("p5_src", acc_src, 1);
        @(posedge clk); #1;
        cyc(3);
        acc_ack = 1;
        cyc(1);
        acc_ack = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("p5_nogrant", acc_valid, 0);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;

        // reset mid-word
        enable = 1; req_valid = 2'b10; req_data1 = 20'hFFFFF;
        wait_rise("p6_rise");
        cyc(3);
        check("p6_data_pre", acc_data, 20'hFFFFF);
        reset = 1;
        cyc(1);
        reset = 0; req_valid = 2'b11;
        @(negedge clk);
        check("p6_valid", acc_valid, 0);
        check("p6_data", acc_data, 0);
        check("p6_cnt", drop_cnt, 0);
        check("p6_ready", req_ready, 2'b01);
        @(posedge clk); #1;

        // random traffic
        for (int b = 0; b < 8; b++) begin
            pct = (b % 4 == 0) ? 0 : (b % 4 == 1) ? 5 : (b % 4 == 2) ? 30 : 90;
            for (int i = 0; i < 500; i++) begin
                req_valid = 2'($urandom_range(0, 3));
                req_data0 = DW'($urandom);
                req_data1 = DW'($urandom);
                enable    = ($urandom_range(0, 9) != 0);
                acc_ack   = ($urandom_range(0, 99) < pct);
                clear_err = ($urandom_range(0, 49) == 0);
                reset     = ($urandom_range(0, 399) == 0);
                cyc(1);
            end
        end
        reset = 0; clear_err = 0; acc_ack = 0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
